// File: rtl/ifu_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_stage_pkg;

  localparam int unsigned PC_W             = 32;
  localparam int unsigned INSTR_W          = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [PC_W-1:0] PC_INC           = 32'd4;
  localparam logic [PC_W-1:0] PC_ALIGN_MASK    = 32'hffff_fffc;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_stage_fetch_fifo.sv
// Circular queue of {pc, instr} entries between icache capture and decode.
module fetch_fifo
  import ifu_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq,
  input  logic             deq,
  input  fetch_entry_t     enq_data,
  output fetch_entry_t     deq_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             deq_s;

  assign deq_s = deq && (count_r != '0);
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == '0);

  // Pointer and occupancy update; flush drops everything including a same-cycle dequeue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq)   tail_r <= tail_r + PTR_ONE;
      if (deq_s) head_r <= head_r + PTR_ONE;
      case ({enq, deq_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage; a full queue may write the head slot as it is being read out.
  always_ff @(posedge clk) begin
    if (enq && !flush && !reset) mem_r[tail_r] <= enq_data;
  end

  // Head is presented only when valid so stale storage never reaches decode.
  always_comb begin
    if (count_r == '0) begin
      deq_data = '0;
    end else begin
      deq_data = mem_r[head_r];
    end
  end

endmodule

// File: rtl/ifu_fetch_stage.sv
// Fetch stage: PC register, IDLE/FETCH control and the decode-facing queue.
// Optional FETCH_STALL_CNT_EN adds a stall_cycles counter for full-queue stalls.
module ifu_fetch_stage
  import ifu_fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned     QUEUE_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    fetch_address,
  input  logic [INSTR_W-1:0] instruction,
  output logic               deq_valid,
  output logic [PC_W-1:0]    deq_pc,
  output logic [INSTR_W-1:0] deq_instr,
  input  logic               deq_ready
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e     state_r;
  fetch_state_e     state_next_s;
  logic [PC_W-1:0]  pc_r;
  logic             enq_s;
  logic             stall_s;
  logic             deq_fire_s;
  logic             room_s;
  logic [CNT_W-1:0] count_s;
  logic             full_s;
  logic             empty_s;
  fetch_entry_t     enq_entry_s;
  fetch_entry_t     head_entry_s;

  assign deq_valid     = !empty_s;
  assign deq_fire_s    = deq_valid && deq_ready;
  assign room_s        = (count_s < CNT_W'(QUEUE_DEPTH));
  assign fetch_address = pc_r;
  assign deq_pc        = head_entry_s.pc;
  assign deq_instr     = head_entry_s.instr;
  assign enq_entry_s   = '{pc: pc_r, instr: instruction};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state follows fetch_en; redirects leave the state alone.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = fetch_en ? FETCH : IDLE;
      FETCH:   state_next_s = fetch_en ? FETCH : IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Enqueue and stall decode; a redirect suppresses both for its cycle.
  always_comb begin
    enq_s   = 1'b0;
    stall_s = 1'b0;
    case (state_r)
      FETCH: begin
        if (redirect_valid) begin
          enq_s   = 1'b0;
          stall_s = 1'b0;
        end else begin
          enq_s   = room_s || deq_fire_s;
          stall_s = full_s && !deq_fire_s;
        end
      end
      IDLE: begin
        enq_s   = 1'b0;
        stall_s = 1'b0;
      end
      default: begin
        enq_s   = 1'b0;
        stall_s = 1'b0;
      end
    endcase
  end

  // PC register: redirect target is word-aligned, sequential fetch wraps at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= redirect_pc & PC_ALIGN_MASK;
    end else if (enq_s) begin
      pc_r <= pc_r + PC_INC;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Full-queue stall counter, survives redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
    end else if (stall_s) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  logic stall_unused_s;
  assign stall_unused_s = stall_s;
`endif

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .enq      (enq_s),
    .deq      (deq_fire_s),
    .enq_data (enq_entry_s),
    .deq_data (head_entry_s),
    .count    (count_s),
    .full     (full_s),
    .empty    (empty_s)
  );

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Directed and random checks of ifu_fetch_stage against a queue-based reference model.
module tb_ifu_fetch_stage;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_address;
  logic [31:0] instruction;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic        deq_ready;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int vec_cnt;
  int err_cnt;

  // Reference model state
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_fetching;
  logic [31:0] m_stall;

  function automatic logic [31:0] cache_word(input logic [31:0] a);
    return {16'hffff, a[31:28], a[13:2]};
  endfunction

  assign instruction = cache_word(fetch_address);

  ifu_fetch_stage #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_address  (fetch_address),
    .instruction    (instruction),
    .deq_valid      (deq_valid),
    .deq_pc         (deq_pc),
    .deq_instr      (deq_instr),
    .deq_ready      (deq_ready)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    check("fetch_address", fetch_address, m_pc);
    check("deq_valid", {31'd0, deq_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      check("deq_pc", deq_pc, m_q[0][63:32]);
      check("deq_instr", deq_instr, m_q[0][31:0]);
    end
`ifdef FETCH_STALL_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
`endif
  endtask

  // One clock: compare current outputs, apply inputs, advance the model, step past the edge.
  task automatic cycle(input bit rst, input bit fen, input bit rv,
                       input logic [31:0] rpc, input bit rdy);
    bit fire;
    bit can;
    reset = rst; fetch_en = fen; redirect_valid = rv; redirect_pc = rpc; deq_ready = rdy;
    check_model();
    if (rst) begin
      m_pc = RPC; m_q.delete(); m_fetching = 0; m_stall = 32'd0;
    end else begin
      fire = (m_q.size() != 0) && rdy;
      if (rv) begin
        m_pc = {rpc[31:2], 2'b00};
        m_q.delete();
      end else begin
        can = m_fetching && (m_q.size() < DEPTH || fire);
        if (m_fetching && m_q.size() == DEPTH && !fire) m_stall = m_stall + 32'd1;
        if (fire) void'(m_q.pop_front());
        if (can) begin
          m_q.push_back({m_pc, cache_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
      m_fetching = fen;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] fa;
    vec_cnt = 0; err_cnt = 0;
    m_pc = RPC; m_fetching = 0; m_stall = 32'd0;
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; deq_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset values
    check("rst_fetch_address", fetch_address, 32'h8000_0000);
    check("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
    check("rst_deq_pc", deq_pc, 32'd0);
    check("rst_deq_instr", deq_instr, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    check("rst_stall", stall_cycles, 32'd0);
`endif

    // Startup latency and first two instructions
    cycle(0, 1, 0, 0, 1);
    check("start_deq_valid", {31'd0, deq_valid}, 32'd0);
    cycle(0, 1, 0, 0, 1);
    check("c2_deq_pc", deq_pc, 32'h8000_0000);
    check("c2_deq_instr", deq_instr, 32'hffff_8000);
    cycle(0, 1, 0, 0, 1);
    check("c3_deq_pc", deq_pc, 32'h8000_0004);
    check("c3_deq_instr", deq_instr, 32'hffff_8001);

    // Back-pressure: queue fills, PC sticks, then drains in order
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 1, 0, 0, 0);
    check("bp_fetch_address", fetch_address, 32'h8000_0010);
    check("bp_deq_valid", {31'd0, deq_valid}, 32'd1);
`ifdef FETCH_STALL_CNT_EN
    check("bp_stall", stall_cycles, 32'd6);
`endif
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", deq_pc, 32'h8000_0000 + 32'(4 * i));
      cycle(0, 0, 0, 0, 1);
    end

    // Redirect with three entries queued
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 32'h7000_0003, 0);
    check("redir_deq_valid", {31'd0, deq_valid}, 32'd0);
    check("redir_fetch_address", fetch_address, 32'h7000_0000);
    cycle(0, 1, 0, 0, 1);
    check("redir_head_pc", deq_pc, 32'h7000_0000);
    check("redir_head_instr", deq_instr, 32'hffff_7000);

    // Full queue with decode ready keeps streaming
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      fa = fetch_address;
      cycle(0, 1, 0, 0, 1);
      check("full_stream_pc", fetch_address, fa + 32'd4);
    end

    // Reset overrides a same-cycle redirect
    cycle(1, 1, 1, 32'h1234_5678, 1);
    check("rst_redir_fa", fetch_address, 32'h8000_0000);
    check("rst_redir_valid", {31'd0, deq_valid}, 32'd0);
    cycle(0, 1, 0, 0, 1);
    check("rst_idle_valid", {31'd0, deq_valid}, 32'd0);

    // PC wrap
    cycle(0, 1, 1, 32'hffff_fffc, 1);
    check("wrap_pre", fetch_address, 32'hffff_fffc);
    cycle(0, 1, 0, 0, 1);
    check("wrap_post", fetch_address, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 15) == 0),
            $urandom(),
            ($urandom_range(0, 9) < 6));
    end
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
